// File: rtl/mips_32_pkg.sv
// Shared opcodes, instruction classes and pipeline-register payloads for the mips_32 core.
package mips_32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX = 5;
  localparam int unsigned OPW  = 6;

  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_AND   = 6'b000010;
  localparam logic [OPW-1:0] OP_OR    = 6'b000011;
  localparam logic [OPW-1:0] OP_SLT   = 6'b000100;
  localparam logic [OPW-1:0] OP_MUL   = 6'b000101;
  localparam logic [OPW-1:0] OP_LW    = 6'b001000;
  localparam logic [OPW-1:0] OP_SW    = 6'b001001;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001010;
  localparam logic [OPW-1:0] OP_SUBI  = 6'b001011;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001100;
  localparam logic [OPW-1:0] OP_BNEQZ = 6'b001101;
  localparam logic [OPW-1:0] OP_BEQZ  = 6'b001110;
  localparam logic [OPW-1:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    NOP, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  } itype_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] ir;
  } if_id_t;

  typedef struct packed {
    logic            valid;
    itype_t          itype;
    logic [OPW-1:0]  op;
    logic [RIDX-1:0] rs;
    logic [RIDX-1:0] rt;
    logic [RIDX-1:0] dest;
    logic            wr;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    itype_t          itype;
    logic [RIDX-1:0] dest;
    logic            wr;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    itype_t          itype;
    logic [RIDX-1:0] dest;
    logic            wr;
    logic [XLEN-1:0] result;
  } mem_wb_t;

  function automatic itype_t decode_type(input logic [OPW-1:0] op);
    itype_t t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                    t = RM_ALU;
      OP_LW:                                        t = LOAD;
      OP_SW:                                        t = STORE;
      OP_BNEQZ, OP_BEQZ:                            t = BRANCH;
      OP_HLT:                                       t = HALT;
      default:                                      t = NOP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips_32_alu.sv
// Combinational ALU; memory ops reuse the adder for address generation.
module mips_32_alu
  import mips_32_pkg::*;
(
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
      OP_SUB, OP_SUBI:               result = a - b;
      OP_AND:                        result = a & b;
      OP_OR:                         result = a | b;
      OP_SLT, OP_SLTI:               result = XLEN'($signed(a) < $signed(b));
      OP_MUL:                        result = a * b;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/mips_32.sv
// Five-stage MIPS-subset core with a unified word-addressed memory, EX-stage
// forwarding, EX-resolved branches and a halt that drains older instructions.
module mips_32
  import mips_32_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [XLEN-1:0] Reg [0:31];
  logic [XLEN-1:0] Mem [0:MEM_WORDS-1];
  logic [XLEN-1:0] PC;
  logic            HALTED;
  logic            TAKEN_BRANCH;

  if_id_t  if_id, if_id_n;
  id_ex_t  id_ex, id_ex_n;
  ex_mem_t ex_mem, ex_mem_n;
  mem_wb_t mem_wb, mem_wb_n;

  logic [XLEN-1:0] pc_n;
  logic            halted_n;

  logic [OPW-1:0]  id_op;
  logic [RIDX-1:0] id_rs, id_rt, id_rd, id_dest;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  itype_t          id_type;
  logic            wb_we;

  logic [XLEN-1:0] ex_a, ex_b, alu_b, alu_result, br_target;
  logic            ex_fwd_ok, taken;
  logic [XLEN-1:0] mem_rdata;
  logic            store_we, fetch_stop;

  assign halted = HALTED;

  // Decode and register read; a WB write in the same cycle is visible here.
  always_comb begin
    id_op   = if_id.ir[31:26];
    id_rs   = if_id.ir[25:21];
    id_rt   = if_id.ir[20:16];
    id_rd   = if_id.ir[15:11];
    id_imm  = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
    id_type = decode_type(id_op);
    id_dest = (id_type == RR_ALU) ? id_rd : id_rt;
    wb_we   = mem_wb.valid && mem_wb.wr;
    id_a    = '0;
    id_b    = '0;
    if (id_rs != '0)
      id_a = (wb_we && mem_wb.dest == id_rs) ? mem_wb.result : Reg[id_rs];
    if (id_rt != '0)
      id_b = (wb_we && mem_wb.dest == id_rt) ? mem_wb.result : Reg[id_rt];
  end

  // Operand forwarding: EX/MEM overrides MEM/WB because it is younger.
  always_comb begin
    ex_fwd_ok = ex_mem.valid && ex_mem.wr && (ex_mem.itype != LOAD);
    ex_a = id_ex.a;
    ex_b = id_ex.b;
    if (wb_we && mem_wb.dest == id_ex.rs) ex_a = mem_wb.result;
    if (wb_we && mem_wb.dest == id_ex.rt) ex_b = mem_wb.result;
    if (ex_fwd_ok && ex_mem.dest == id_ex.rs) ex_a = ex_mem.alu_out;
    if (ex_fwd_ok && ex_mem.dest == id_ex.rt) ex_b = ex_mem.alu_out;
    alu_b     = (id_ex.itype == RR_ALU) ? ex_b : id_ex.imm;
    br_target = id_ex.npc + id_ex.imm;
    taken     = id_ex.valid && (id_ex.itype == BRANCH) &&
                ((id_ex.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
  end

  mips_32_alu u_alu (
    .op     (id_ex.op),
    .a      (ex_a),
    .b      (alu_b),
    .result (alu_result)
  );

  always_comb begin
    mem_rdata  = Mem[ex_mem.alu_out[AW-1:0]];
    store_we   = ex_mem.valid && (ex_mem.itype == STORE);
    fetch_stop = (if_id.valid  && if_id.ir[31:26] == OP_HLT) ||
                 (id_ex.valid  && id_ex.itype  == HALT) ||
                 (ex_mem.valid && ex_mem.itype == HALT) ||
                 (mem_wb.valid && mem_wb.itype == HALT);
  end

  // Next-state for PC and every pipeline register.
  always_comb begin
    pc_n     = PC;
    if_id_n  = '0;
    id_ex_n  = '0;
    ex_mem_n = '0;
    mem_wb_n = '0;
    halted_n = HALTED || (mem_wb.valid && mem_wb.itype == HALT);

    if (taken) begin
      pc_n = br_target;
    end else if (!fetch_stop) begin
      if_id_n.valid = 1'b1;
      if_id_n.ir    = Mem[PC[AW-1:0]];
      if_id_n.npc   = PC + 32'd1;
      pc_n          = PC + 32'd1;
    end

    id_ex_n.valid = if_id.valid && !taken;
    id_ex_n.itype = id_type;
    id_ex_n.op    = id_op;
    id_ex_n.rs    = id_rs;
    id_ex_n.rt    = id_rt;
    id_ex_n.dest  = id_dest;
    id_ex_n.wr    = ((id_type == RR_ALU) || (id_type == RM_ALU) || (id_type == LOAD)) &&
                    (id_dest != '0);
    id_ex_n.npc   = if_id.npc;
    id_ex_n.a     = id_a;
    id_ex_n.b     = id_b;
    id_ex_n.imm   = id_imm;

    ex_mem_n.valid      = id_ex.valid;
    ex_mem_n.itype      = id_ex.itype;
    ex_mem_n.dest       = id_ex.dest;
    ex_mem_n.wr         = id_ex.wr;
    ex_mem_n.alu_out    = alu_result;
    ex_mem_n.store_data = ex_b;

    mem_wb_n.valid  = ex_mem.valid;
    mem_wb_n.itype  = ex_mem.itype;
    mem_wb_n.dest   = ex_mem.dest;
    mem_wb_n.wr     = ex_mem.wr;
    mem_wb_n.result = (ex_mem.itype == LOAD) ? mem_rdata : ex_mem.alu_out;
  end

  // Everything freezes once HALTED is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      if_id        <= '0;
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
    end else if (!HALTED) begin
      PC           <= pc_n;
      HALTED       <= halted_n;
      TAKEN_BRANCH <= taken;
      if_id        <= if_id_n;
      id_ex        <= id_ex_n;
      ex_mem       <= ex_mem_n;
      mem_wb       <= mem_wb_n;
    end
  end

  // Architectural storage is not reset; bubbles never write.
  always_ff @(posedge clk) begin
    if (!HALTED && wb_we)
      Reg[mem_wb.dest] <= mem_wb.result;
    if (!HALTED && store_we)
      Mem[ex_mem.alu_out[AW-1:0]] <= ex_mem.store_data;
  end

endmodule

// File: tb/tb_mips_32.sv
// Directed and randomized programs for mips_32, checked against an
// instruction-level interpreter and hand-derived constants.
module tb_mips_32;

  localparam int unsigned MEM_WORDS = 1024;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010;
  localparam logic [5:0] T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101;
  localparam logic [5:0] T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010;
  localparam logic [5:0] T_SUBI = 6'b001011, T_SLTI = 6'b001100;
  localparam logic [5:0] T_BNEQZ = 6'b001101, T_BEQZ = 6'b001110, T_HLT = 6'b111111;
  localparam logic [5:0] T_NOP = 6'b000110, T_ODD = 6'b010000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  mips_32 #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  int cycles, taken_cnt, stay_cnt;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] prog [$];

  function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called with rst_n low: clear memory, Reg[k]=k, load prog at address 0.
  task automatic preload();
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      dut.Mem[i] = '0;
      m_mem[i]   = '0;
    end
    for (int k = 0; k < 32; k++) begin
      dut.Reg[k] = 32'(k);
      m_reg[k]   = 32'(k);
    end
    for (int i = 0; i < prog.size(); i++) begin
      dut.Mem[i] = prog[i];
      m_mem[i]   = prog[i];
    end
  endtask

  task automatic set_reg(input int k, input logic [31:0] v);
    dut.Reg[k] = v;
    m_reg[k]   = v;
  endtask

  task automatic set_mem(input int a, input logic [31:0] v);
    dut.Mem[a] = v;
    m_mem[a]   = v;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  // Release reset and count rising edges until halted, bounded.
  task automatic run_prog(input int budget);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    taken_cnt = 0;
    while (halted !== 1'b1 && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  // Sequential instruction-set interpreter over m_reg/m_mem.
  task automatic model_run();
    int pc;
    logic [31:0] ir, a, b, imm, res;
    logic [5:0] op;
    int rs, rt, rd, dst;
    logic wr;
    pc = 0;
    for (int step = 0; step < 2000; step++) begin
      ir  = m_mem[pc % int'(MEM_WORDS)];
      op  = ir[31:26];
      rs  = int'(ir[25:21]);
      rt  = int'(ir[20:16]);
      rd  = int'(ir[15:11]);
      imm = {{16{ir[15]}}, ir[15:0]};
      a   = (rs == 0) ? 32'd0 : m_reg[rs];
      b   = (rt == 0) ? 32'd0 : m_reg[rt];
      wr  = 1'b0;
      dst = rd;
      res = '0;
      pc  = pc + 1;
      case (op)
        T_ADD:  begin wr = 1'b1; res = a + b; end
        T_SUB:  begin wr = 1'b1; res = a - b; end
        T_AND:  begin wr = 1'b1; res = a & b; end
        T_OR:   begin wr = 1'b1; res = a | b; end
        T_SLT:  begin wr = 1'b1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        T_MUL:  begin wr = 1'b1; res = a * b; end
        T_ADDI: begin wr = 1'b1; dst = rt; res = a + imm; end
        T_SUBI: begin wr = 1'b1; dst = rt; res = a - imm; end
        T_SLTI: begin wr = 1'b1; dst = rt; res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; end
        T_LW:   begin wr = 1'b1; dst = rt; res = m_mem[(a + imm) % MEM_WORDS]; end
        T_SW:   m_mem[(a + imm) % MEM_WORDS] = b;
        T_BNEQZ: if (a != 0) pc = pc + int'($signed(imm));
        T_BEQZ:  if (a == 0) pc = pc + int'($signed(imm));
        default: ;
      endcase
      if (op == T_HLT) break;
      if (wr && dst != 0) m_reg[dst] = res;
    end
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);

    // Regression program
    prog = '{32'h28010078, 32'h0C631800, 32'h20220000, 32'h0C631800,
             32'h2842002D, 32'h0C631800, 32'h24220001, 32'hFC000000};
    preload();
    set_mem(120, 32'd60);
    run_prog(15);
    check("reg_mem121", dut.Mem[121], 32'd105);
    check("reg_r1", dut.Reg[1], 32'd120);
    check("reg_r2", dut.Reg[2], 32'd105);
    check("reg_cycles", 32'(cycles), 32'd12);

    // Distance-1 forwarding
    enter_reset();
    prog = '{enc_i(T_ADDI, 0, 1, 5), enc_i(T_ADDI, 1, 2, 3), enc_i(T_HLT, 0, 0, 0)};
    preload();
    run_prog(40);
    check("fwd_r2", dut.Reg[2], 32'd8);
    check("fwd_cycles", 32'(cycles), 32'd7);

    // Taken branch
    enter_reset();
    prog = '{enc_i(T_ADDI, 0, 1, 0), enc_i(T_BEQZ, 1, 0, 2), enc_i(T_ADDI, 0, 5, 7),
             enc_i(T_ADDI, 0, 6, 7), enc_i(T_ADDI, 0, 7, 9), enc_i(T_HLT, 0, 0, 0)};
    preload();
    set_reg(1, 32'h11);
    set_reg(5, 32'h55);
    set_reg(6, 32'h66);
    run_prog(40);
    check("br_r5", dut.Reg[5], 32'h55);
    check("br_r6", dut.Reg[6], 32'h66);
    check("br_r7", dut.Reg[7], 32'd9);
    check("br_pulses", 32'(taken_cnt), 32'd1);
    check("br_cycles", 32'(cycles), 32'd10);

    // Arithmetic and R0
    enter_reset();
    prog = '{enc_i(T_ADDI, 0, 0, 9), enc_i(T_SUBI, 0, 3, 1), enc_r(T_SLT, 3, 0, 4),
             enc_i(T_ADDI, 0, 5, 256), enc_r(T_MUL, 5, 5, 6), enc_r(T_MUL, 6, 6, 7),
             enc_i(T_HLT, 0, 0, 0)};
    preload();
    run_prog(40);
    check("ar_r0", dut.Reg[0], 32'd0);
    check("ar_r3", dut.Reg[3], 32'hFFFF_FFFF);
    check("ar_r4", dut.Reg[4], 32'd1);
    check("ar_r6", dut.Reg[6], 32'h0001_0000);
    check("ar_r7", dut.Reg[7], 32'd0);

    // Halt and hold
    enter_reset();
    prog = '{enc_i(T_ADDI, 0, 1, 3), enc_i(T_HLT, 0, 0, 0),
             enc_i(T_ADDI, 0, 8, 1), enc_i(T_ADDI, 0, 8, 1)};
    preload();
    set_reg(8, 32'h88);
    run_prog(40);
    check("hlt_cycles", 32'(cycles), 32'd6);
    stay_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (halted === 1'b1) stay_cnt++;
    end
    check("hlt_stays", 32'(stay_cnt), 32'd20);
    check("hlt_r8", dut.Reg[8], 32'h88);
    check("hlt_r1", dut.Reg[1], 32'd3);
    check("hlt_pc", dut.PC, 32'd2);

    // Reset while SW is in EX
    enter_reset();
    prog = '{enc_i(T_SW, 0, 2, 300), enc_i(T_HLT, 0, 0, 0)};
    preload();
    set_reg(2, 32'h1234);
    set_mem(300, 32'hDEAD);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_pc", dut.PC, 32'd0);
    check("mid_halted", 32'(halted), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_mem", dut.Mem[300], 32'hDEAD);
    run_prog(40);
    check("mid_restart_mem", dut.Mem[300], 32'h1234);
    check("mid_restart_cycles", 32'(cycles), 32'd6);

    // Random programs against the interpreter
    for (int seed = 0; seed < 3; seed++) begin
      enter_reset();
      prog.delete();
      for (int n = 0; n < 16; n++) begin
        int kind;
        kind = int'($urandom_range(0, 9));
        if (kind <= 5)
          prog.push_back(enc_r(6'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
        else if (kind == 6)
          prog.push_back(enc_i(6'($urandom_range(10, 12)), int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 7)), int'($urandom_range(0, 65535))));
        else if (kind == 7)
          prog.push_back(enc_i(T_SW, 0, int'($urandom_range(0, 7)), 200 + int'($urandom_range(0, 15))));
        else if (kind == 8) begin
          prog.push_back(enc_i(T_LW, 0, int'($urandom_range(0, 7)), 200 + int'($urandom_range(0, 15))));
          prog.push_back(enc_i(T_NOP, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0));
        end else
          prog.push_back(enc_i(T_ODD, int'($urandom_range(0, 7)), int'($urandom_range(1, 7)), 1));
      end
      prog.push_back(enc_i(T_HLT, 0, 0, 0));
      preload();
      for (int k = 1; k < 8; k++) set_reg(k, $urandom);
      for (int a = 200; a < 216; a++) set_mem(a, $urandom);
      model_run();
      run_prog(200);
      for (int k = 0; k < 8; k++)
        check($sformatf("rnd%0d_r%0d", seed, k), dut.Reg[k], m_reg[k]);
      for (int a = 200; a < 216; a++)
        check($sformatf("rnd%0d_m%0d", seed, a), dut.Mem[a], m_mem[a]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
